// File: rtl/rggen_register_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_register_initiator                                                   |
// | Host-side initiator broadcasting one register access at a time, with      |
// | OR-merged responses, decode-error detection and a bounded-wait timeout.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rggen_register_initiator #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1,
  parameter int TIMEOUT       = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_host_valid,
  output logic                           o_host_ready,
  input  logic                           i_host_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
  input  logic [BUS_WIDTH-1:0]           i_host_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_host_strobe,
  output logic                           o_host_resp_valid,
  input  logic                           i_host_resp_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_reg_valid,
  output logic [1:0]                     o_reg_access,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_reg_strobe,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [2*REGISTERS-1:0]         i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;
  // A zero-width counter is illegal, so TIMEOUT == 0 still keeps one bit.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     host_ready_q;
  logic                     reg_valid_q;
  logic                     resp_valid_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STRB_W-1:0]        strobe_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         count_d;

  logic [REGISTERS-1:0]     hit;
  logic [1:0]               merged_status;
  logic [BUS_WIDTH-1:0]     merged_data;
  logic                     no_decode;
  logic                     done;
  logic                     timed_out;

  assign hit       = i_reg_active & i_reg_ready;
  assign no_decode = ~|i_reg_active;
  assign done      = |hit;
  assign timed_out = (TIMEOUT != 0) && (count_q == TIMEOUT_LAST);
  // Saturate rather than wrap so a disabled timeout can never alias.
  assign count_d   = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    merged_status = '0;
    merged_data   = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (hit[k]) begin
        merged_status = merged_status | i_reg_status[2*k+:2];
        merged_data   = merged_data | i_reg_read_data[BUS_WIDTH*k+:BUS_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      host_ready_q <= 1'b1;
      reg_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_host_valid) begin
            write_q      <= i_host_write;
            address_q    <= i_host_address;
            write_data_q <= i_host_write ? i_host_write_data : '0;
            strobe_q     <= i_host_write ? i_host_strobe : '1;
            count_q      <= '0;
            host_ready_q <= 1'b0;
            reg_valid_q  <= 1'b1;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Priority: decode error, then completion, then timeout.
          if (no_decode) begin
            status_q     <= STATUS_DECODE_ERROR;
            read_data_q  <= '0;
            reg_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (done) begin
            status_q     <= merged_status;
            read_data_q  <= merged_data;
            reg_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (timed_out) begin
            status_q     <= STATUS_SLAVE_ERROR;
            read_data_q  <= '0;
            reg_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            count_q <= count_d;
          end
        end
        ST_RESP: begin
          if (i_host_resp_ready) begin
            resp_valid_q <= 1'b0;
            host_ready_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          host_ready_q <= 1'b1;
          reg_valid_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_host_ready      = host_ready_q;
  assign o_host_resp_valid = resp_valid_q;
  assign o_host_status     = status_q;
  assign o_host_read_data  = read_data_q;
  assign o_reg_valid       = reg_valid_q;
  assign o_reg_access      = {1'b0, write_q};
  assign o_reg_address     = address_q;
  assign o_reg_write_data  = write_data_q;
  assign o_reg_strobe      = strobe_q;

endmodule
`default_nettype wire
